// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter owner and single-entry fetch buffer feeding the execute controller
// Optional macro FETCH_COUNT_EN adds a saturating count of accepted instructions on fetch_count.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  output logic                  halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]           fetch_count
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALTED} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic [DATA_WIDTH-1:0] ir_data_q, ir_data_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      ir_pc_q   <= '0;
      ir_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_pc_q   <= ir_pc_d;
      ir_data_q <= ir_data_d;
    end
  end

  // halt outranks branch_taken; both discard any same-cycle memory word or held instruction
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_pc_d   = ir_pc_q;
    ir_data_d = ir_data_q;
    if (state_q != HALTED && halt) begin
      state_d = HALTED;
    end else if (state_q != HALTED && branch_taken) begin
      pc_d    = branch_target;
      state_d = FETCH;
    end else begin
      case (state_q)
        BOOT:  state_d = FETCH;
        FETCH: begin
          if (mem_ready) begin
            ir_data_d = mem_rdata;
            ir_pc_d   = pc_q;
            pc_d      = pc_q + PC_STEP;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) state_d = FETCH;
        end
        HALTED:  state_d = HALTED;
        default: state_d = BOOT;
      endcase
    end
  end

  assign mem_req  = (state_q == FETCH);
  assign mem_addr = pc_q;
  assign ir_valid = (state_q == HOLD);
  assign ir_data  = ir_data_q;
  assign ir_pc    = ir_pc_q;
  assign halted   = (state_q == HALTED);

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (state_q == HOLD && ir_ready && !halt && !branch_taken && fetch_count_q != 16'hFFFF)
      fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) fetch_count_q <= '0;
    else       fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } xfer_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic        halted;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int    checks = 0;
  int    errors = 0;
  int    xfer_cnt = 0;
  int    cyc_n = 0;
  xfer_t exp_q[$];
  int    xfer_cyc[$];
  logic [15:0] slow_addr = 16'h0005;
  int    slow_waits = 3;
  int    wait_cnt = 0;

  instruction_fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .halted(halted)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc_n++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory: word = addr + 0xC000, wait states only at slow_addr
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req && !reset) begin
        if (mem_addr == slow_addr && wait_cnt < slow_waits) begin
          mem_ready = 1'b0;
          wait_cnt++;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr + 16'hC000;
          wait_cnt  = 0;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Monitor: every accepted transfer is popped from the scoreboard
  initial forever begin
    @(negedge clock);
    if (!reset && ir_valid && ir_ready && !branch_taken && !halt) begin
      xfer_cnt++;
      xfer_cyc.push_back(cyc_n);
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_pc", {16'h0, ir_pc}, 32'hDEAD);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        chk("xfer_data", {16'h0, ir_data}, {16'h0, e.data});
        chk("xfer_pc", {16'h0, ir_pc}, {16'h0, e.pc});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_xfer(input int n);
    int k = 0;
    while (xfer_cnt < n && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("wait_xfer_timeout", {31'h0, xfer_cnt >= n}, 32'h1);
  endtask

  task automatic wait_valid();
    int k = 0;
    @(negedge clock);
    while (!ir_valid && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("wait_valid_timeout", {31'h0, ir_valid}, 32'h1);
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] p);
    xfer_t e;
    e.data = d;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ir_ready = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    step();
    @(negedge clock);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_ir_data", {16'h0, ir_data}, 32'h0);
    chk("rst_ir_pc", {16'h0, ir_pc}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    step();
    reset = 1'b0; ir_ready = 1'b1;
    push(16'hC000, 16'h0000); push(16'hC001, 16'h0001);
    push(16'hC002, 16'h0002); push(16'hC003, 16'h0003);
    @(negedge clock);
    chk("boot_no_req", {31'h0, mem_req}, 32'h0);
    step();
    @(negedge clock);
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", {16'h0, mem_addr}, 32'h0);

    wait_xfer(3);
    chk("gap_0_1", xfer_cyc[1] - xfer_cyc[0], 32'd2);
    chk("gap_1_2", xfer_cyc[2] - xfer_cyc[1], 32'd2);
    step();
    ir_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", {16'h0, ir_data}, 32'hC003);
      chk("hold_pc", {16'h0, ir_pc}, 32'h0003);
      chk("hold_no_req", {31'h0, mem_req}, 32'h0);
      @(negedge clock);
    end
    push(16'hC004, 16'h0004); push(16'hC005, 16'h0005);
    step();
    ir_ready = 1'b1;
    step();
    @(negedge clock);
    chk("after_hold_addr", {16'h0, mem_addr}, 32'h0004);

    begin
      int k = 0;
      while (!(mem_req && mem_addr == 16'h0005) && k < 50) begin
        @(negedge clock);
        k++;
      end
      for (int i = 0; i < 4; i++) begin
        chk("wait_req", {31'h0, mem_req}, 32'h1);
        chk("wait_addr", {16'h0, mem_addr}, 32'h0005);
        chk("wait_no_valid", {31'h0, ir_valid}, 32'h0);
        @(negedge clock);
      end
      chk("wait_capture_valid", {31'h0, ir_valid}, 32'h1);
    end

    wait_xfer(6);
    step();
    ir_ready = 1'b0;
    wait_valid();
    chk("pre_branch_pc", {16'h0, ir_pc}, 32'h0006);
    chk("pre_branch_data", {16'h0, ir_data}, 32'hC006);
    step();
    ir_ready = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
    step();
    branch_target = 16'hFFFF;
    @(negedge clock);
    chk("br_drop_valid", {31'h0, ir_valid}, 32'h0);
    chk("br_req", {31'h0, mem_req}, 32'h1);
    chk("br_addr", {16'h0, mem_addr}, 32'h0040);
    chk("br_mem_ready", {31'h0, mem_ready}, 32'h1);
    push(16'hBFFF, 16'hFFFF); push(16'hC000, 16'h0000);
    step();
    branch_taken = 1'b0;
    @(negedge clock);
    chk("br2_addr", {16'h0, mem_addr}, 32'hFFFF);
    chk("br2_discard_valid", {31'h0, ir_valid}, 32'h0);

    wait_xfer(8);
    step();
    halt = 1'b1;
    @(negedge clock);
    chk("halt_mem_ready", {31'h0, mem_ready}, 32'h1);
    step();
    halt = 1'b0; branch_taken = 1'b1; branch_target = 16'h0010;
    @(negedge clock);
    chk("halted", {31'h0, halted}, 32'h1);
    chk("halt_ir_valid", {31'h0, ir_valid}, 32'h0);
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("halt_no_req", {31'h0, mem_req}, 32'h0);
      chk("halt_stay", {31'h0, halted}, 32'h1);
`ifdef FETCH_COUNT_EN
      chk("fetch_count_frozen", {16'h0, fetch_count}, 32'd8);
`endif
    end
    chk("xfer_total", xfer_cnt, 32'd8);

    step();
    reset = 1'b1; ir_ready = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst2_halted", {31'h0, halted}, 32'h0);
    chk("rst2_boot_no_req", {31'h0, mem_req}, 32'h0);
    chk("rst2_ir_valid", {31'h0, ir_valid}, 32'h0);
`ifdef FETCH_COUNT_EN
    chk("rst2_fetch_count", {16'h0, fetch_count}, 32'd0);
`endif
    step();
    @(negedge clock);
    chk("rst2_req", {31'h0, mem_req}, 32'h1);
    chk("rst2_addr", {16'h0, mem_addr}, 32'h0000);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
